// File: rtl/store_data_unit_pkg.sv
// store_pkg: shared types and the store formatting function for store_data_unit.
// Build option: define STORE_MISALIGN_TRAP_EN to trap misaligned stores instead of force-aligning them.
`default_nettype none

package store_pkg;

   // Entry address width is fixed at the widest supported AW; the top narrows it on output.
   localparam int ST_AW_MAX = 64;

   typedef enum logic [1:0] {
      ST_BYTE = 2'b00,
      ST_HALF = 2'b01,
      ST_WORD = 2'b10,
      ST_RSVD = 2'b11
   } st_size_e;

   typedef struct packed {
      logic [ST_AW_MAX-1:0] addr;
      logic [31:0]          wdata;
      logic [3:0]           be;
   } st_entry_t;

   typedef struct packed {
      st_entry_t entry;
      logic      err;
   } st_fmt_t;

   function automatic st_fmt_t fmt_store(input logic [ST_AW_MAX-1:0] addr,
                                         input logic [31:0]          data,
                                         input st_size_e             size);
      st_fmt_t    r;
      logic [1:0] lo;
      r  = '0;
      lo = addr[1:0];
      r.entry.addr = {addr[ST_AW_MAX-1:2], 2'b00};
      // Half lane choice ignores addr[0] and word always enables all lanes,
      // which is exactly the force-align behaviour of the non-trapping build.
      case (size)
         ST_BYTE: begin
            r.entry.be    = 4'b0001 << lo;
            r.entry.wdata = {4{data[7:0]}};
         end
         ST_HALF: begin
            r.entry.be    = lo[1] ? 4'b1100 : 4'b0011;
            r.entry.wdata = {2{data[15:0]}};
         end
         ST_WORD: begin
            r.entry.be    = 4'b1111;
            r.entry.wdata = data;
         end
         default: r.err = 1'b1;
      endcase
`ifdef STORE_MISALIGN_TRAP_EN
      if ((size == ST_HALF && lo[0]) || (size == ST_WORD && lo != 2'b00))
         r.err = 1'b1;
`else
`endif
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/store_data_unit_if.sv
// store_data_unit_if: request, memory-drain and status signals of the store data unit.
`default_nettype none

interface store_data_unit_if
   import store_pkg::*;
#(
   parameter int AW    = 32,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          req_valid;
   logic          req_ready;
   logic [AW-1:0] req_addr;
   logic [31:0]   req_data;
   logic [1:0]    req_size;
   logic          mem_valid;
   logic          mem_ready;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [3:0]    mem_be;
   logic          store_err;
   logic          empty;
   logic [CW-1:0] count;

   modport master (
      output req_valid, req_addr, req_data, req_size, mem_ready,
      input  req_ready, mem_valid, mem_addr, mem_wdata, mem_be, store_err, empty, count
   );

   modport slave (
      input  req_valid, req_addr, req_data, req_size, mem_ready,
      output req_ready, mem_valid, mem_addr, mem_wdata, mem_be, store_err, empty, count
   );

endinterface

`default_nettype wire

// File: rtl/store_data_unit_fifo.sv
// store_fifo: DEPTH-entry FIFO of formatted stores; wrapping pointers, count separates full from empty.
`default_nettype none

module store_fifo
   import store_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = st_entry_t
) (
   input  wire logic                   clk,
   input  wire logic                   rst,
   input  wire logic                   i_push,
   input  wire T                       i_data,
   input  wire logic                   i_pop,
   output T                            o_data,
   output logic [$clog2(DEPTH):0]      o_count,
   output logic                        o_full,
   output logic                        o_empty
);
   localparam int PW = $clog2(DEPTH);

   T              r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [PW:0]   r_count;
   logic          w_push;
   logic          w_pop;

   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_full  = (r_count == (PW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_data  = r_mem[r_rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage is not reset; the top masks the head while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= i_data;
   end

endmodule

`default_nettype wire

// File: rtl/store_data_unit.sv
// store_data_unit: formats SB/SH/SW stores into byte lanes and drains them through a store buffer.
// Build option: STORE_MISALIGN_TRAP_EN (see store_pkg) selects trapping of misaligned stores.
`default_nettype none

module store_data_unit
   import store_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 32
) (
   input  wire logic          clk,
   input  wire logic          reset,
   store_data_unit_if.slave   bus
);
   localparam int CW = $clog2(DEPTH) + 1;

   st_fmt_t       w_fmt;
   st_entry_t     w_head;
   logic          w_accept;
   logic          w_push;
   logic          w_pop;
   logic          w_full;
   logic          w_empty;
   logic [CW-1:0] w_count;
   logic          r_store_err;

   assign w_fmt    = fmt_store(ST_AW_MAX'(bus.req_addr), bus.req_data, st_size_e'(bus.req_size));
   assign w_accept = bus.req_valid && !w_full;
   assign w_push   = w_accept && !w_fmt.err;
   assign w_pop    = !w_empty && bus.mem_ready;

   store_fifo #(
      .DEPTH (DEPTH),
      .T     (st_entry_t)
   ) u_fifo (
      .clk     (clk),
      .rst     (reset),
      .i_push  (w_push),
      .i_data  (w_fmt.entry),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_store_err <= 1'b0;
      else
         r_store_err <= w_accept && w_fmt.err;
   end

   assign bus.req_ready = !w_full;
   assign bus.mem_valid = !w_empty;
   assign bus.mem_addr  = w_empty ? '0 : w_head.addr[AW-1:0];
   assign bus.mem_wdata = w_empty ? '0 : w_head.wdata;
   assign bus.mem_be    = w_empty ? '0 : w_head.be;
   assign bus.store_err = r_store_err;
   assign bus.empty     = w_empty;
   assign bus.count     = w_count;

   // Entry address bits above AW are always zero and intentionally dropped.
   generate
      if (AW < ST_AW_MAX) begin : g_addr_hi
         logic w_unused_addr_hi;
         assign w_unused_addr_hi = ^w_head.addr[ST_AW_MAX-1:AW];
      end
   endgenerate

endmodule

`default_nettype wire

// File: doc/store_data_unit.md
Name: store_data_unit

Overview:
- Store-path counterpart to the load-side sign extender in the MIPS datapath.
- Takes a 32-bit register value plus byte address and size (SB/SH/SW), and narrows it to the addressed byte lanes with byte enables.
- Buffers formatted stores in a small FIFO and drains them to data memory over a valid/ready handshake.
- Sits between the MEM stage and the data memory port.

Parameters:
- DEPTH, 4, store buffer entries; power of two, ≥2.
- AW, 32, address width.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  store request present
- req_ready  out  1  buffer can accept a request
- req_addr  in  AW  byte address
- req_data  in  32  register rt value
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- mem_valid  out  1  head entry presented to memory
- mem_ready  in  1  memory accepts the head entry
- mem_addr  out  AW  word-aligned address, low 2 bits forced to 0
- mem_wdata  out  32  lane-replicated write data
- mem_be  out  4  byte enables; bit i selects lane data[8i+7:8i]
- store_err  out  1  one-cycle pulse: misaligned or reserved-size request
- empty  out  1  buffer holds no entries
- count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset values (asynchronous): req_ready=1, mem_valid=0, mem_addr=0, mem_wdata=0, mem_be=0, store_err=0, empty=1, count=0. Pointers are cleared and buffered entries discarded.
- Reset mid-operation: any undrained stores are lost. Memory must tolerate a dropped handshake.
- Accept: a request is accepted on a cycle where req_valid && req_ready. req_ready = (count != DEPTH), combinational from registered state only.
- Formatting at accept time (little-endian lanes):
  - byte: be = 4'b0001 << addr[1:0]; wdata = {4{data[7:0]}}.
  - half: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{data[15:0]}}.
  - word: be = 4'b1111; wdata = data.
- Error cases:
  - Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
  - Reserved: size 11.
  - Handling for both is defined under Optional Feature.
- Drain:
  - mem_valid = !empty; mem_* show the head entry.
  - The entry pops on mem_valid && mem_ready.
  - mem_* hold stable while mem_valid && !mem_ready.
- Latency: an entry accepted in cycle N appears on mem_* in cycle N+1 at the earliest. There is no combinational request-to-memory path.
- Simultaneous push and pop:
  - Allowed when not full; count is unchanged.
  - When full, req_ready=0, so no push occurs even if a pop happens that cycle.
- Pointers wrap modulo DEPTH. count distinguishes full from empty.
- store_err is registered and asserts the cycle after the offending accept. An erroneous request never enters the buffer, is never written to memory, and never changes count.

Optional Feature:
- Macro: STORE_MISALIGN_TRAP_EN.
- Defined: a misaligned request raises store_err and is dropped.
- Undefined:
  - A misaligned request is force-aligned: addr[0] is cleared for half, addr[1:0] for word.
  - It is buffered normally with no store_err.
  - Reserved size 11 still pulses store_err and is dropped in both builds.

Decomposition:
- Package store_pkg:
  - enum st_size_e {ST_BYTE, ST_HALF, ST_WORD, ST_RSVD}.
  - struct st_entry_t {addr, wdata, be}.
  - Function fmt_store(addr, data, size) returning st_entry_t plus an error flag.
- Sub-module store_fifo, parameterised on DEPTH and entry type: storage, pointers, count.
- Top level holds formatting, error logic and handshake glue.

Test Plan:
- Reset check: assert reset mid-drain with 3 entries -> count=0, empty=1, mem_valid=0 immediately; req_ready=1.
- SB: addr=0x1003, data=0xAABBCC7F -> next cycle mem_addr=0x1000, mem_be=1000, mem_wdata=0x7F7F7F7F.
- SH/SW: SH addr=0x2002, data=0x1234ABCD -> be=1100, wdata=0xABCDABCD. SW addr=0x2004 -> be=1111, wdata=data.
- Backpressure: hold mem_ready=0 and push DEPTH stores -> req_ready=0 at count=4; mem_* stable. Release mem_ready for one cycle -> count=3, req_ready=1; FIFO order is preserved.
- Concurrent push/pop at count=2 -> count stays 2; pointer wrap after 10 total stores gives correct ordering.
- Errors:
  - SW at 0x3002 with trap build -> store_err pulse, count unchanged.
  - Same request without trap build -> mem_addr=0x3000, be=1111.
  - Size 11 -> store_err in both builds.
